perf_uart_arbiter: RTL

Message-level round-robin arbiter that shares the single byte sink feeding the UART TX FIFO between up to NREQ report generators (cache event counters, debug dumpers). Each requester streams ASCII bytes with a last-byte marker. Once a requester is granted, it keeps the grant for its whole message, so messages from different requesters are never interleaved. A watchdog releases a stalled requester so that it cannot lock out the others.

---
 rtl/perf_uart_arbiter_if.sv | 49 ++++
 rtl/perf_uart_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/perf_uart_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : perf_uart_arbiter_if
// Description : Requester lanes and UART FIFO write port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface perf_uart_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              full;
    logic [7:0]        data_o;
    logic              wr_en;
    logic [NREQ-1:0]   grant_o;
    logic              busy;
    logic [7:0]        abort_cnt;

    // Requesters plus the FIFO status side.
    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output full,
        input  req_ready,
        input  data_o,
        input  wr_en,
        input  grant_o,
        input  busy,
        input  abort_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  full,
        output req_ready,
        output data_o,
        output wr_en,
        output grant_o,
        output busy,
        output abort_cnt
    );
endinterface
`default_nettype wire

// File: rtl/perf_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : perf_uart_arbiter
// Description : Message-level round-robin arbiter with starvation watchdog
//               feeding a single UART TX FIFO byte port.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_uart_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rstn,
    perf_uart_arbiter_if.slave  bus
);
    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_stv_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_ptr_w:0]   c_nreq     = (c_ptr_w+1)'(NREQ);
    localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(NREQ - 1);
    localparam logic [c_stv_w-1:0] c_stv_max  = c_stv_w'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]    c_oh_one   = {{(NREQ-1){1'b0}}, 1'b1};

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_xfer = 1'b1;

    logic [0:0]         r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] r_g;
    logic [c_stv_w-1:0] r_starve;
    logic [NREQ-1:0]    r_grant;
    logic [7:0]         r_data;
    logic               r_wr_en;
    logic [7:0]         r_abort_cnt;

    logic               w_any;
    logic [c_ptr_w-1:0] w_pick;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic               w_own_valid;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic               w_accept;
    logic               w_starved_out;

    // Rotating priority: the lowest offset from r_ptr with a valid lane wins,
    // so iterate from the farthest offset down and let nearer hits overwrite.
    always_comb begin : p_pick
        logic [c_ptr_w:0] v_sum;
        w_any  = |bus.req_valid;
        w_pick = r_ptr;
        v_sum  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_ptr} + (c_ptr_w+1)'(k);
            if (v_sum >= c_nreq) begin
                v_sum = v_sum - c_nreq;
            end
            if (bus.req_valid[v_sum[c_ptr_w-1:0]]) begin
                w_pick = v_sum[c_ptr_w-1:0];
            end
        end
    end

    assign w_next_ptr    = (r_g == c_last_idx) ? '0 : r_g + 1'b1;
    assign w_own_valid   = bus.req_valid[r_g];
    assign w_own_last    = bus.req_last[r_g];
    assign w_own_data    = bus.req_data[{r_g, 3'b000} +: 8];
    assign w_accept      = (r_state == c_xfer) && w_own_valid && !bus.full;
    assign w_starved_out = (r_state == c_xfer) && !w_own_valid && (r_starve == c_stv_max);

    // Only the owner lane sees ready, and only while the FIFO has room.
    for (genvar i = 0; i < NREQ; i++) begin : g_ready
        assign bus.req_ready[i] = (r_state == c_xfer) && (r_g == c_ptr_w'(i)) && !bus.full;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_idle;
            r_ptr       <= '0;
            r_g         <= '0;
            r_starve    <= '0;
            r_grant     <= '0;
            r_data      <= 8'h00;
            r_wr_en     <= 1'b0;
            r_abort_cnt <= 8'h00;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_g      <= w_pick;
                        r_grant  <= c_oh_one << w_pick;
                        r_starve <= '0;
                        r_state  <= c_xfer;
                    end
                end
                c_xfer: begin
                    if (w_accept) begin
                        r_data   <= w_own_data;
                        r_wr_en  <= 1'b1;
                        r_starve <= '0;
                        if (w_own_last) begin
                            r_state <= c_idle;
                            r_grant <= '0;
                            r_ptr   <= w_next_ptr;
                        end
                    end else if (w_starved_out) begin
                        // Watchdog: drop the silent owner so others get a turn.
                        r_state  <= c_idle;
                        r_grant  <= '0;
                        r_ptr    <= w_next_ptr;
                        r_starve <= '0;
                        if (r_abort_cnt != 8'hFF) begin
                            r_abort_cnt <= r_abort_cnt + 8'h01;
                        end
                    end else if (!w_own_valid) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.data_o    = r_data;
    assign bus.wr_en     = r_wr_en;
    assign bus.grant_o   = r_grant;
    assign bus.busy      = (r_state == c_xfer);
    assign bus.abort_cnt = r_abort_cnt;

endmodule
`default_nettype wire
